// File: rtl/fpro_avalon_bridge.sv
// rtl/fpro_avalon_bridge.sv - Avalon-MM slave to FPro bus bridge with region decode and fixed read latency
module fpro_avalon_bridge #(
  parameter int                ADDR_W        = 21,
  parameter int                DATA_W        = 32,
  parameter int                READ_LAT      = 1,
  parameter int                MMIO_AW       = 11,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] fp_address,
  output logic [DATA_W-1:0] fp_writedata,
  input  logic [DATA_W-1:0] fp_readdata,
  output logic              fp_write,
  output logic              fp_read,
  output logic              fp_mmio_cs,
  output logic              fp_video_cs,
  output logic [15:0]       unmapped_cnt
);

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

  // WAIT runs READ_LAT cycles; the counter hits zero on the last one.
  localparam logic [1:0] WAIT_LOAD = (READ_LAT > 0) ? 2'(READ_LAT - 1) : 2'd0;

  state_t     state;
  state_t     state_next;
  logic       op_write;
  logic       op_mmio;
  logic       op_video;
  logic [1:0] wait_cnt;
  logic       req;
  logic       hit_mmio;
  logic       hit_video;

  // Decode the incoming request and its target region.
  always_comb begin
    req       = avs_read | avs_write;
    hit_video = avs_address[ADDR_W-1];
    hit_mmio  = !avs_address[ADDR_W-1] && (avs_address[ADDR_W-2:MMIO_AW] == '0);
  end

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and state-derived strobes, selects and waitrequest.
  always_comb begin
    state_next      = state;
    avs_waitrequest = 1'b1;
    fp_write        = 1'b0;
    fp_read         = 1'b0;
    fp_mmio_cs      = 1'b0;
    fp_video_cs     = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_next = (hit_mmio || hit_video) ? STROBE : DONE;
      end
      STROBE: begin
        fp_write    = op_write;
        fp_read     = !op_write;
        fp_mmio_cs  = op_mmio;
        fp_video_cs = op_video;
        state_next  = (op_write || READ_LAT == 0) ? DONE : WAIT;
      end
      WAIT: begin
        if (wait_cnt == 2'd0) state_next = DONE;
      end
      DONE: begin
        avs_waitrequest = 1'b0;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the request, count unmapped hits and sample read data at the latency point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fp_address   <= '0;
      fp_writedata <= '0;
      avs_readdata <= '0;
      op_write     <= 1'b0;
      op_mmio      <= 1'b0;
      op_video     <= 1'b0;
      wait_cnt     <= 2'd0;
      unmapped_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            fp_address   <= avs_address;
            fp_writedata <= avs_writedata;
            op_write     <= avs_write;
            op_mmio      <= hit_mmio;
            op_video     <= hit_video;
            if (!hit_mmio && !hit_video) begin
              if (unmapped_cnt != 16'hFFFF) unmapped_cnt <= unmapped_cnt + 16'd1;
              if (!avs_write) avs_readdata <= UNMAPPED_DATA;
            end
          end
        end
        STROBE: begin
          wait_cnt <= WAIT_LOAD;
          if (!op_write && READ_LAT == 0) avs_readdata <= fp_readdata;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) avs_readdata <= fp_readdata;
          else                  wait_cnt     <= wait_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpro_avalon_bridge.sv
// tb/tb_fpro_avalon_bridge.sv - scoreboard bench for fpro_avalon_bridge
module tb_fpro_avalon_bridge;

  localparam int ADDR_W   = 21;
  localparam int DATA_W   = 32;
  localparam int READ_LAT = 2;
  localparam int MMIO_AW  = 11;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [DATA_W-1:0] avs_writedata = '0;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_waitrequest;
  logic [ADDR_W-1:0] fp_address;
  logic [DATA_W-1:0] fp_writedata;
  logic [DATA_W-1:0] fp_readdata = '0;
  logic              fp_write;
  logic              fp_read;
  logic              fp_mmio_cs;
  logic              fp_video_cs;
  logic [15:0]       unmapped_cnt;

  fpro_avalon_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT),
    .MMIO_AW(MMIO_AW), .UNMAPPED_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .fp_address(fp_address), .fp_writedata(fp_writedata), .fp_readdata(fp_readdata),
    .fp_write(fp_write), .fp_read(fp_read),
    .fp_mmio_cs(fp_mmio_cs), .fp_video_cs(fp_video_cs),
    .unmapped_cnt(unmapped_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    bit              wr;
    bit              mmio;
    bit              video;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } strobe_t;

  typedef struct {
    int              start;
    int              lat;
    logic [DATA_W-1:0] rdata;
    logic [15:0]     cnt;
  } done_t;

  strobe_t sq[$];
  done_t   cq[$];

  int   cyc = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  bit   mon_en = 1'b0;
  logic hist[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

  logic [DATA_W-1:0] model_rd = '0;
  logic [15:0]       model_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  function automatic logic [DATA_W-1:0] fab(input logic [ADDR_W-1:0] a);
    return {a[20:0], 11'h5A5} ^ 32'hCAFE_F00D;
  endfunction

  always @(posedge clk) cyc++;

  // Fabric: read data is valid exactly READ_LAT cycles after the fp_read strobe, garbage otherwise.
  always @(posedge clk) begin
    #1;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = fp_read;
    fp_readdata = hist[READ_LAT] ? fab(fp_address) : $urandom;
  end

  // Monitor: compare strobes and completions against queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      if (fp_write || fp_read) begin
        if (sq.size() == 0) begin
          chk("strobe_unexpected", {fp_write, fp_read}, 2'b00);
        end else begin
          strobe_t e;
          e = sq.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          chk("strobe_type", {fp_write, fp_read}, {e.wr, !e.wr});
          chk("strobe_cs", {fp_mmio_cs, fp_video_cs}, {e.mmio, e.video});
          chk("fp_address", fp_address, e.addr);
          if (e.wr) chk("fp_writedata", fp_writedata, e.wdata);
        end
      end else begin
        chk("cs_idle", {fp_mmio_cs, fp_video_cs}, 2'b00);
      end
      if (!avs_waitrequest) begin
        if (cq.size() == 0) begin
          chk("done_unexpected", avs_waitrequest, 1'b1);
        end else begin
          done_t d;
          d = cq.pop_front();
          chk("latency", cyc - d.start + 1, d.lat);
          chk("avs_readdata", avs_readdata, d.rdata);
          chk("unmapped_cnt", unmapped_cnt, d.cnt);
        end
      end
    end
  end

  // One Avalon transfer; op 0=read, 1=write, 2=read+write. Called at posedge+1, returns at posedge+1.
  task automatic xfer(input logic [ADDR_W-1:0] addr, input int op, input logic [DATA_W-1:0] wdata);
    bit      video, mmio, wr, ok;
    strobe_t s;
    done_t   d;
    video = (addr >= (1 << (ADDR_W - 1)));
    mmio  = (addr < (1 << MMIO_AW));
    wr    = (op != 0);
    d.start = cyc;
    if (video || mmio) begin
      s.cyc = cyc + 1; s.wr = wr; s.mmio = mmio; s.video = video;
      s.addr = addr; s.wdata = wdata;
      sq.push_back(s);
      if (!wr) model_rd = fab(addr);
      d.lat = wr ? 3 : 3 + READ_LAT;
    end else begin
      if (model_cnt != 16'hFFFF) model_cnt++;
      if (!wr) model_rd = 32'hDEAD_BEEF;
      d.lat = 2;
    end
    d.rdata = model_rd;
    d.cnt   = model_cnt;
    cq.push_back(d);
    avs_address   = addr;
    avs_writedata = wdata;
    avs_read      = (op != 1);
    avs_write     = (op != 0);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (!avs_waitrequest) begin ok = 1'b1; break; end
    end
    if (!ok) chk("xfer_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_waitrequest", avs_waitrequest, 1'b1);
    chk("rst_outputs", {avs_readdata, fp_write, fp_read, fp_mmio_cs, fp_video_cs}, '0);
    chk("rst_fp_regs", {fp_address, fp_writedata}, '0);
    chk("rst_unmapped_cnt", unmapped_cnt, 16'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a read strobe.
    avs_address = 21'h00010;
    avs_read    = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_strobe", {fp_read, fp_mmio_cs}, 2'b11);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_strobe", {fp_read, fp_mmio_cs, fp_video_cs, fp_write}, 4'b0000);
    chk("async_rst_waitreq", avs_waitrequest, 1'b1);
    avs_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post_rst_cnt", unmapped_cnt, 16'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;

    // Directed transfers.
    xfer(21'h00005, 1, 32'h1234_5678);
    xfer(21'h100020, 0, 32'h0);
    xfer(21'h000800, 0, 32'h0);
    xfer(21'h00001, 1, 32'hA5A5_0001);
    xfer(21'h00002, 0, 32'h0);
    xfer(21'h00003, 2, 32'h0BAD_0003);

    // Randomized transfers with random gaps, including back-to-back.
    for (int i = 0; i < 150; i++) begin
      logic [ADDR_W-1:0] a;
      int region;
      region = $urandom_range(0, 2);
      case (region)
        0:       a = ADDR_W'($urandom_range(0, (1 << MMIO_AW) - 1));
        1:       a = ADDR_W'(32'h100000 | $urandom_range(0, 32'hFFFFF));
        default: a = ADDR_W'($urandom_range(1 << MMIO_AW, 32'hFFFFF));
      endcase
      xfer(a, $urandom_range(0, 2), $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (6) @(posedge clk);
    #1;
    chk("strobe_queue_empty", sq.size(), 0);
    chk("done_queue_empty", cq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fpro_avalon_bridge.md
Name: fpro_avalon_bridge

Overview:
- Avalon-MM slave that sits inside the Nios system directly upstream of the exported FPro bus conduit.
- Converts each Avalon read or write into a single-cycle FPro strobe.
- Decodes the word address into the MMIO or video chip-select.
- Waits a fixed read latency, captures read data, then completes the Avalon transfer using waitrequest.

Parameters:
- ADDR_W, 21: word-address width of both the Avalon and FPro sides.
- DATA_W, 32: data width.
- READ_LAT, 1: cycles from the fp_read strobe to valid fp_readdata. Legal range 0..3.
- MMIO_AW, 11: MMIO region is word addresses 0 .. 2^MMIO_AW-1.
- UNMAPPED_DATA, 32'hDEAD_BEEF: read data returned for unmapped addresses.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- avs_address  in  ADDR_W  Avalon word address
- avs_read  in  1  Avalon read request
- avs_write  in  1  Avalon write request
- avs_writedata  in  DATA_W  Avalon write data
- avs_readdata  out  DATA_W  Avalon read data, valid while avs_waitrequest=0 after a read
- avs_waitrequest  out  1  Avalon stall; 0 for exactly one cycle per completed transfer
- fp_address  out  ADDR_W  registered FPro address
- fp_writedata  out  DATA_W  registered FPro write data
- fp_readdata  in  DATA_W  FPro read data from the slot/video fabric
- fp_write  out  1  FPro write strobe
- fp_read  out  1  FPro read strobe
- fp_mmio_cs  out  1  MMIO region select
- fp_video_cs  out  1  video region select
- unmapped_cnt  out  16  saturating count of unmapped accesses

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - FSM=IDLE.
  - avs_waitrequest=1.
  - avs_readdata=0, fp_address=0, fp_writedata=0.
  - fp_write, fp_read, fp_mmio_cs, fp_video_cs all 0.
  - unmapped_cnt=0.
- Reset asserted mid-transfer drops all strobes and selects immediately (asynchronously). The FSM returns to IDLE and the transfer is abandoned.
- Address decode (applied to avs_address in IDLE):
  - Video when bit ADDR_W-1 = 1.
  - MMIO when bit ADDR_W-1 = 0 and bits ADDR_W-2 .. MMIO_AW are all 0.
  - Everything else is unmapped.
- FSM states: IDLE, STROBE, WAIT, DONE.
- IDLE:
  - avs_waitrequest=1.
  - On avs_write or avs_read, register avs_address into fp_address, avs_writedata into fp_writedata, the operation type and the region.
  - Mapped access: go to STROBE.
  - Unmapped access: go to DONE, increment unmapped_cnt (saturating at 16'hFFFF), load avs_readdata=UNMAPPED_DATA on reads, and issue no strobe or select.
- Simultaneous avs_read and avs_write: treated as a write; the read is ignored.
- STROBE (exactly 1 cycle):
  - The region's cs=1, plus fp_write=1 or fp_read=1.
  - Write: next state is DONE.
  - Read with READ_LAT=0: sample fp_readdata into avs_readdata at the end of this cycle, then go to DONE.
  - Read with READ_LAT>0: go to WAIT.
- WAIT (READ_LAT cycles, tracked by a 2-bit down-counter):
  - cs and strobes are 0; fp_address is held.
  - On the final WAIT cycle, fp_readdata is sampled into avs_readdata; then go to DONE.
- DONE (1 cycle): avs_waitrequest=0, avs_readdata is stable; next state is IDLE.
- The master drops its request after the DONE edge. A request present in IDLE on the following cycle is treated as a new transfer; back-to-back transfers are allowed.
- Latency:
  - Write: 3 cycles from request to completion.
  - Read: 3+READ_LAT cycles.
  - Unmapped access: 2 cycles.
- fp_address and fp_writedata hold their last value between transfers.
- avs_readdata holds until the next read completes; writes do not change it.

Test Plan:
- Reset: assert reset mid-STROBE of a read to 0x00010 -> fp_read and fp_mmio_cs fall to 0 without waiting for a clock edge; avs_waitrequest=1; after release, FSM is in IDLE and unmapped_cnt=0.
- MMIO write to 0x00005, data 0x12345678 -> cycle 1: fp_write=1, fp_mmio_cs=1, fp_address=0x00005, fp_writedata=0x12345678; cycle 2: avs_waitrequest=0; cycle 3: waitrequest=1 and all strobes 0.
- Video read from 0x100020 with READ_LAT=1 and fp_readdata=0xCAFEF00D during WAIT -> fp_video_cs=1 only in STROBE; avs_readdata=0xCAFEF00D with waitrequest=0 in cycle 3.
- Unmapped read from 0x000800 -> no strobe or select ever asserted; avs_readdata=0xDEADBEEF with waitrequest=0 in cycle 1; unmapped_cnt=1.
- Back-to-back write to 0x00001 then read from 0x00002 (READ_LAT=2) -> both complete; the read's waitrequest falls exactly 5 cycles after the write's DONE cycle, with data sampled 2 cycles after fp_read.
- Simultaneous avs_read=1 and avs_write=1 to 0x00003 -> only fp_write pulses; avs_readdata is unchanged.
